// File: rtl/sram_nrmw_init_bypass.sv
// -----------------------------------------------------------------------------
// sram_nrmw_init_bypass
//
// Multi-port register-file SRAM with binary-encoded addresses, internal
// decode, defined write-port priority, optional write-to-read bypass,
// optional registered read, and a post-reset init sweep that leaves the low
// region [0, PRESERVE_LO) untouched.
//
// Ports:
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   raddr_i      NUM_RD packed read addresses, port k at [k*SRAM_INDEX +: SRAM_INDEX]
//   rdata_o      NUM_RD packed read data, port k at [k*SRAM_WIDTH +: SRAM_WIDTH]
//   we_i         per-port write enable
//   waddr_i      NUM_WR packed write addresses
//   wdata_i      NUM_WR packed write data
//   init_busy_o  high while the init sweep is pending or running
// -----------------------------------------------------------------------------
module sram_nrmw_init_bypass #(
  parameter int SRAM_DEPTH    = 64,
  parameter int SRAM_INDEX    = 6,
  parameter int SRAM_WIDTH    = 8,
  parameter int NUM_RD        = 12,
  parameter int NUM_WR        = 6,
  parameter int PRESERVE_LO   = 32,
  parameter int INIT_IDENTITY = 0,
  parameter int READ_REG      = 0,
  parameter int BYPASS        = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD*SRAM_INDEX-1:0]   raddr_i,
  output logic [NUM_RD*SRAM_WIDTH-1:0]   rdata_o,
  input  logic [NUM_WR-1:0]              we_i,
  input  logic [NUM_WR*SRAM_INDEX-1:0]   waddr_i,
  input  logic [NUM_WR*SRAM_WIDTH-1:0]   wdata_i,
  output logic                           init_busy_o
);

  localparam int PtrW = SRAM_INDEX + 1;

  // The pointer is one bit wider than an address so it can hold SRAM_DEPTH
  // even when the depth is a full power of two.
  localparam logic [SRAM_INDEX:0] LpDepth    = PtrW'(SRAM_DEPTH);
  localparam logic [SRAM_INDEX:0] LpPreserve = PtrW'(PRESERVE_LO);
  localparam logic [SRAM_INDEX:0] LpPtrOne   = PtrW'(1);

  logic [SRAM_INDEX:0] r_init_ptr;
  logic                w_init_busy;

  // Flattened view of the storage, one lane per entry, for the read muxes.
  logic [SRAM_DEPTH-1:0][SRAM_WIDTH-1:0] w_mem;

  // Unpacked views of the packed address/data buses.
  logic [SRAM_INDEX-1:0] w_raddr [NUM_RD];
  logic [SRAM_INDEX-1:0] w_waddr [NUM_WR];
  logic [SRAM_WIDTH-1:0] w_wdata [NUM_WR];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign w_raddr[k] = raddr_i[k*SRAM_INDEX +: SRAM_INDEX];
  end

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
    assign w_waddr[p] = waddr_i[p*SRAM_INDEX +: SRAM_INDEX];
    assign w_wdata[p] = wdata_i[p*SRAM_WIDTH +: SRAM_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Init sweep pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_ptr <= LpPreserve;
    end else if (w_init_busy) begin
      r_init_ptr <= r_init_ptr + LpPtrOne;
    end
  end

  if (PRESERVE_LO >= SRAM_DEPTH) begin : g_no_sweep
    // Nothing to sweep: busy is tied off so it is never X, even before reset.
    assign w_init_busy = 1'b0;
  end else begin : g_sweep
    assign w_init_busy = (r_init_ptr < LpDepth);
  end

  assign init_busy_o = w_init_busy;

  // ---------------------------------------------------------------------------
  // Storage: one register per entry with its own write decode
  // ---------------------------------------------------------------------------
  for (genvar e = 0; e < SRAM_DEPTH; e++) begin : g_ent
    localparam logic [SRAM_WIDTH-1:0] InitVal =
      (INIT_IDENTITY != 0) ? SRAM_WIDTH'(e) : {SRAM_WIDTH{1'b0}};

    logic                  w_wr_en;
    logic [SRAM_WIDTH-1:0] w_wr_data;
    logic [SRAM_WIDTH-1:0] r_entry;

    always_comb begin
      w_wr_en   = 1'b0;
      w_wr_data = '0;
      if (w_init_busy) begin
        // The sweep owns the array; functional writes are discarded.
        if (r_init_ptr == PtrW'(e)) begin
          w_wr_en   = 1'b1;
          w_wr_data = InitVal;
        end
      end else begin
        // Ascending scan: the highest-indexed matching port wins.
        for (int p = 0; p < NUM_WR; p++) begin
          if (we_i[p] && (w_waddr[p] == SRAM_INDEX'(e))) begin
            w_wr_en   = 1'b1;
            w_wr_data = w_wdata[p];
          end
        end
      end
    end

    // No reset on the data itself: preserved entries must survive reset, and
    // the array is never written while reset is high.
    always_ff @(posedge clk) begin
      if (!reset && w_wr_en) begin
        r_entry <= w_wr_data;
      end
    end

    assign w_mem[e] = r_entry;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic                  w_in_range;
    logic [SRAM_WIDTH-1:0] w_rval;

    assign w_in_range = ({1'b0, w_raddr[k]} < LpDepth);

    always_comb begin
      w_rval = '0;
      if (w_in_range) begin
        w_rval = w_mem[w_raddr[k]];
      end
      // Forward a same-cycle functional write; sweep writes are never forwarded.
      if ((BYPASS != 0) && !w_init_busy && w_in_range) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (we_i[p] && (w_waddr[p] == w_raddr[k])) begin
            w_rval = w_wdata[p];
          end
        end
      end
    end

    if (READ_REG != 0) begin : g_reg
      logic [SRAM_WIDTH-1:0] r_rdata;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata <= '0;
        end else begin
          r_rdata <= w_rval;
        end
      end

      assign rdata_o[k*SRAM_WIDTH +: SRAM_WIDTH] = r_rdata;
    end else begin : g_comb
      assign rdata_o[k*SRAM_WIDTH +: SRAM_WIDTH] = w_rval;
    end
  end

endmodule

// File: tb/tb_sram_nrmw_init_bypass.sv
// -----------------------------------------------------------------------------
// tb_sram_nrmw_init_bypass
//
// Directed bench for sram_nrmw_init_bypass. Three instances share one set of
// inputs:
//   u_def : default parameters (comb read, bypass, preserve 0..31 of 64)
//   u_nob : as u_def but without bypass
//   u_id  : 48 deep, identity init, nothing preserved, registered read
// Inputs change just after a negedge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_sram_nrmw_init_bypass;

  localparam int Idx = 6;
  localparam int W   = 8;
  localparam int Nr  = 12;
  localparam int Nw  = 6;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [Nr*Idx-1:0]   raddr;
  logic [Nw-1:0]       we;
  logic [Nw*Idx-1:0]   waddr;
  logic [Nw*W-1:0]     wdata;

  logic [Nr*W-1:0]     rdata_def, rdata_nob, rdata_id;
  logic                busy_def, busy_nob, busy_id;

  int n_checks = 0;
  int n_errors = 0;

  sram_nrmw_init_bypass u_def (
    .clk         (clk),
    .reset       (reset),
    .raddr_i     (raddr),
    .rdata_o     (rdata_def),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .init_busy_o (busy_def)
  );

  sram_nrmw_init_bypass #(
    .BYPASS (0)
  ) u_nob (
    .clk         (clk),
    .reset       (reset),
    .raddr_i     (raddr),
    .rdata_o     (rdata_nob),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .init_busy_o (busy_nob)
  );

  sram_nrmw_init_bypass #(
    .SRAM_DEPTH    (48),
    .SRAM_INDEX    (6),
    .PRESERVE_LO   (0),
    .INIT_IDENTITY (1),
    .READ_REG      (1)
  ) u_id (
    .clk         (clk),
    .reset       (reset),
    .raddr_i     (raddr),
    .rdata_o     (rdata_id),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .init_busy_o (busy_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [Nr*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_rd(input int a);
    for (int k = 0; k < Nr; k++) raddr[k*Idx +: Idx] = Idx'(a);
  endtask

  task automatic wr(input int p, input int a, input logic [W-1:0] d);
    we[p]               = 1'b1;
    waddr[p*Idx +: Idx] = Idx'(a);
    wdata[p*W +: W]     = d;
  endtask

  task automatic clr_wr();
    we = '0;
  endtask

  // Called at a negedge; counts sampled busy cycles over n cycles and
  // returns positioned at a negedge.
  task automatic count_busy(input int n, output int c_def, output int c_nob, output int c_id);
    c_def = 0;
    c_nob = 0;
    c_id  = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (busy_def) c_def++;
      if (busy_nob) c_nob++;
      if (busy_id)  c_id++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cd, cn, ci;
    reset = 1'b1;
    we    = '0;
    raddr = '0;
    waddr = '0;
    wdata = '0;

    // Power-up reset, two cycles.
    cyc();
    cyc();
    #1;
    check("busy_in_reset_def", busy_def, 1);
    check("busy_in_reset_id", busy_id, 1);
    check("rreg_in_reset", lane(rdata_id, 2), 0);

    reset = 1'b0;
    count_busy(60, cd, cn, ci);
    check("sweep0_len_def", cd, 32);
    check("sweep0_len_nob", cn, 32);
    check("sweep0_len_id", ci, 48);

    // Preload entry 5 and read identity-initialised entry 47.
    wr(0, 5, 8'hAA);
    set_rd(47);
    cyc();
    clr_wr();
    #1;
    check("identity_47_p3", lane(rdata_id, 3), 8'h2F);

    // Second reset: preserved entry 5 survives, upper half swept to zero.
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    check("busy_reset2_def", busy_def, 1);
    check("rreg_reset2_zero", lane(rdata_id, 2), 0);
    reset = 1'b0;
    count_busy(60, cd, cn, ci);
    check("sweep1_len_def", cd, 32);
    check("sweep1_len_id", ci, 48);
    set_rd(5);
    #1;
    check("preserve_5_def", lane(rdata_def, 0), 8'hAA);
    check("preserve_5_nob", lane(rdata_nob, 5), 8'hAA);
    for (int a = 32; a < 64; a++) begin
      set_rd(a);
      #1;
      check($sformatf("swept_%0d", a), lane(rdata_def, a % Nr), 0);
    end
    cyc();

    // Write priority: ports 1 and 4 hit entry 10, port 4 wins.
    set_rd(10);
    wr(1, 10, 8'h11);
    wr(4, 10, 8'h44);
    #1;
    check("prio_bypass_def", lane(rdata_def, 0), 8'h44);
    cyc();
    clr_wr();
    #1;
    check("prio_def", lane(rdata_def, 0), 8'h44);
    check("prio_nob", lane(rdata_nob, 7), 8'h44);
    check("prio_rreg_id", lane(rdata_id, 2), 8'h44);

    // Bypass vs. no bypass on entry 7.
    wr(0, 7, 8'h03);
    cyc();
    clr_wr();
    set_rd(7);
    wr(0, 7, 8'h5C);
    #1;
    check("byp_def_p0", lane(rdata_def, 0), 8'h5C);
    check("byp_def_p11", lane(rdata_def, 11), 8'h5C);
    check("nobyp_old_p0", lane(rdata_nob, 0), 8'h03);
    check("nobyp_old_p11", lane(rdata_nob, 11), 8'h03);
    cyc();
    clr_wr();
    #1;
    check("nobyp_new_p0", lane(rdata_nob, 0), 8'h5C);
    check("nobyp_new_p11", lane(rdata_nob, 11), 8'h5C);
    check("byp_rreg_id", lane(rdata_id, 0), 8'h5C);

    // Registered read latency and out-of-range read.
    wr(0, 20, 8'h9E);
    cyc();
    clr_wr();
    set_rd(20);
    cyc();
    #1;
    check("rreg_20_p2", lane(rdata_id, 2), 8'h9E);
    set_rd(63);
    cyc();
    #1;
    check("rreg_oor_p2", lane(rdata_id, 2), 0);
    check("rreg_oor_p0", lane(rdata_id, 0), 0);

    // Writes during the sweep are dropped and never bypassed; reset at
    // sweep cycle 10 restarts it.
    set_rd(40);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    wr(0, 40, 8'h77);
    wr(1, 5, 8'h77);
    #1;
    check("no_bypass_in_sweep", lane(rdata_def, 0), 0);
    for (int i = 0; i < 10; i++) cyc();
    #1;
    check("busy_at_cycle10", busy_def, 1);
    clr_wr();
    reset = 1'b1;
    cyc();
    #1;
    check("busy_restart_reset", busy_def, 1);
    check("rreg_restart_zero", lane(rdata_id, 2), 0);
    reset = 1'b0;
    count_busy(60, cd, cn, ci);
    check("restart_len_def", cd, 32);
    check("restart_len_id", ci, 48);
    set_rd(40);
    #1;
    check("drop_40_def", lane(rdata_def, 0), 0);
    set_rd(5);
    #1;
    check("drop_5_def", lane(rdata_def, 1), 8'hAA);
    set_rd(40);
    cyc();
    #1;
    check("identity_40_id", lane(rdata_id, 2), 8'h28);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_nrmw_init_bypass.md
Name: sram_nrmw_init_bypass

Overview:
Parametrised multi-port register-file SRAM, the successor to the fixed 12R/6W decoded-address arrays. It is used for rename maps, free lists and similar structures.
- Read and write port counts, widths and depth are generics.
- Addresses are binary-encoded. Decoding is internal.
- Adds optional registered read, write-to-read bypass, a defined write-port priority, and a multi-cycle post-reset init sweep that preserves a low region of entries.

Parameters:
SRAM_DEPTH, 64, number of entries (need not be a power of two)
SRAM_INDEX, 6, address width; 2^SRAM_INDEX >= SRAM_DEPTH
SRAM_WIDTH, 8, entry width in bits
NUM_RD, 12, number of read ports
NUM_WR, 6, number of write ports
PRESERVE_LO, 32, entries [0, PRESERVE_LO) are untouched by reset; range 0..SRAM_DEPTH
INIT_IDENTITY, 0, 0: swept entries are written 0; 1: entry i is written i (truncated to SRAM_WIDTH)
READ_REG, 0, 0: combinational read; 1: read data registered, 1-cycle latency
BYPASS, 1, 1: a same-cycle write forwards to a matching read

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
raddr_i  in  NUM_RD*SRAM_INDEX  read addresses; port k occupies bits [k*SRAM_INDEX +: SRAM_INDEX]
rdata_o  out  NUM_RD*SRAM_WIDTH  read data; port k occupies bits [k*SRAM_WIDTH +: SRAM_WIDTH]
we_i  in  NUM_WR  per-port write enable
waddr_i  in  NUM_WR*SRAM_INDEX  write addresses, packed the same way as raddr_i
wdata_i  in  NUM_WR*SRAM_WIDTH  write data, packed the same way as rdata_o
init_busy_o  out  1  high while the init sweep is pending or running

Behaviour:
Reset and init sweep:
- Internal init pointer init_ptr is [SRAM_INDEX:0].
- While reset is high: init_ptr <= PRESERVE_LO; READ_REG=1 output registers <= 0; the array is not written.
- init_busy_o = (init_ptr < SRAM_DEPTH). It is combinational from init_ptr, so it reads 1 during reset and until the sweep ends. If PRESERVE_LO == SRAM_DEPTH it is constant 0.
- Each non-reset cycle with init_busy_o=1: sram[init_ptr] <= (INIT_IDENTITY ? init_ptr : 0), then init_ptr++.
- The sweep therefore takes SRAM_DEPTH-PRESERVE_LO cycles after reset deasserts.
- Reset asserted mid-sweep restarts it from PRESERVE_LO. Entries already swept are rewritten.
- Preserved entries keep their contents across any reset.
- Array contents before the first completed sweep are undefined, except for swept entries.

Writes:
- All writes (we_i) are ignored while init_busy_o=1.
- Otherwise each port p with we_i[p]=1 and waddr < SRAM_DEPTH writes sram[waddr] on posedge.
- Same-address collision: the highest-indexed enabled port wins.
- waddr >= SRAM_DEPTH: the write is dropped.

Reads:
- Raw value per port k = sram[raddr_k], or 0 when raddr_k >= SRAM_DEPTH.
- With BYPASS=1, init_busy_o=0, and some enabled write port p with waddr_p == raddr_k < SRAM_DEPTH: the value is wdata of the highest such p.
- Init-sweep writes are never bypassed.
- READ_REG=0: rdata_o is that value combinationally. With BYPASS=0, new data is visible the cycle after the write.
- READ_REG=1: rdata_o <= value each posedge. Latency is 1 cycle and reset value is 0.
- BYPASS=1 with READ_REG=1 returns the data being written in the cycle the address was presented.
- Reads are unaffected by init_busy_o other than through the bypass rule.

General:
- All ports are independent; any number may hit the same entry in one cycle.
- No output is X after reset when READ_REG=1.
- Implementation: generate loops over NUM_RD/NUM_WR. No `define dependencies.

Test Plan:
1. Init sweep (defaults): preload sram[5]=0xAA via a write, then pulse reset for 2 cycles. Required: init_busy_o=1 for exactly 32 cycles after reset falls; sram[5] reads 0xAA; sram[32..63] read 0x00.
2. Identity init (INIT_IDENTITY=1, PRESERVE_LO=0, SRAM_DEPTH=48, SRAM_INDEX=6): after reset the sweep lasts 48 cycles; read port 3 at addr 47 returns 0x2F.
3. Write priority: same cycle, we_i[1]=1 addr 10 data 0x11 and we_i[4]=1 addr 10 data 0x44. Required: the next cycle read of 10 returns 0x44.
4. Bypass: READ_REG=0, BYPASS=1, sram[7]=0x03. Write 0x5C to 7 on port 0 while read ports 0 and 11 address 7. Required: both return 0x5C in the same cycle. Repeat with BYPASS=0: both return 0x03, then 0x5C one cycle later.
5. Registered read: READ_REG=1. Present addr 20 (contents 0x9E) at cycle n. Required: rdata_o port 2 = 0x9E at cycle n+1 and 0 during reset. Out-of-range addr 63 on a 48-deep array returns 0.
6. Writes during sweep: issue we_i[0] to addr 40 with 0x77 while init_busy_o=1. Required: the write is dropped and 40 reads 0x00 after the sweep. Reset asserted at sweep cycle 10 restarts the sweep, giving a further 32 busy cycles.
